// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, length codes and length decode for the fetch sequencer
package fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_A,
    FETCH_B,
    FETCH_C,
    HOLD,
    FAULT
  } state_t;

  localparam logic [1:0] LEN_1   = 2'b00;
  localparam logic [1:0] LEN_2   = 2'b01;
  localparam logic [1:0] LEN_3   = 2'b10;
  localparam logic [1:0] LEN_ILL = 2'b11;

  // The illegal code decodes as 3 bytes; the trap build intercepts it before this matters.
  function automatic logic [1:0] len_bytes(input logic [1:0] code);
    case (code)
      LEN_1:   return 2'd1;
      LEN_2:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - program-memory read port and decoder opcode handshake
interface fetch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rdy;
  logic [7:0]        mem_data;
  logic              op_valid;
  logic [23:0]       opcode;
  logic [1:0]        op_len;
  logic [ADDR_W-1:0] op_pc;
  logic              op_ack;

  modport master (
    output mem_req, mem_addr, op_valid, opcode, op_len, op_pc,
    input  mem_rdy, mem_data, op_ack
  );

  modport slave (
    input  mem_req, mem_addr, op_valid, opcode, op_len, op_pc,
    output mem_rdy, mem_data, op_ack
  );
endinterface

// File: rtl/opcode_assembler.sv
// rtl/opcode_assembler.sv - three-byte opcode latch with per-byte load, tail clear and hold
module opcode_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [2:0]  load,
  input  logic [7:0]  data,
  output logic [23:0] opcode
);
  logic [7:0] byte_a;
  logic [7:0] byte_b;
  logic [7:0] byte_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_a <= 8'h00;
      byte_b <= 8'h00;
      byte_c <= 8'h00;
    end else begin
      if (load[0]) byte_a <= data;
      if (clear) begin
        byte_b <= 8'h00;
        byte_c <= 8'h00;
      end
      if (load[1]) byte_b <= data;
      if (load[2]) byte_c <= data;
    end
  end

  assign opcode = {byte_a, byte_b, byte_c};
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC walk, byte fetch FSM and opcode hand-off to the decoder
// FETCH_ILLEGAL_TRAP_EN: length code 11 traps into a sticky FAULT state instead of decoding as 3 bytes.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_sequencer_if.master    bus,
  input  logic                 jmp_en,
  input  logic [ADDR_W-1:0]    jmp_addr,
  input  logic                 halt,
  output logic                 fault
);
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] op_pc;
  logic [1:0]        op_len;
  logic [2:0]        load;
  logic              clear;
  logic              take;
  logic              illegal;

  assign take = bus.mem_req && bus.mem_rdy;

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign illegal = (bus.mem_data[7:6] == LEN_ILL);
  assign fault   = (state == FAULT);
`else
  assign illegal = 1'b0;
  assign fault   = 1'b0;
`endif

  // Request depends only on registered state plus halt/rst, never on mem_rdy.
  assign bus.mem_req  = !rst && ((state == FETCH_A && !halt) || state == FETCH_B || state == FETCH_C);
  assign bus.mem_addr = pc;
  assign bus.op_valid = (state == HOLD);
  assign bus.op_pc    = op_pc;
  assign bus.op_len   = op_len;

  always_comb begin
    state_nxt = state;
    load      = 3'b000;
    clear     = 1'b0;
    if (jmp_en) begin
      state_nxt = FETCH_A;
    end else begin
      case (state)
        FETCH_A: if (take) begin
          load  = 3'b001;
          clear = 1'b1;
          if (illegal)                                 state_nxt = FAULT;
          else if (len_bytes(bus.mem_data[7:6]) == 2'd1) state_nxt = HOLD;
          else                                         state_nxt = FETCH_B;
        end
        FETCH_B: if (take) begin
          load      = 3'b010;
          state_nxt = (op_len == 2'd2) ? HOLD : FETCH_C;
        end
        FETCH_C: if (take) begin
          load      = 3'b100;
          state_nxt = HOLD;
        end
        HOLD: if (bus.op_ack) state_nxt = FETCH_A;
`ifdef FETCH_ILLEGAL_TRAP_EN
        FAULT: state_nxt = FAULT;
`endif
        default: state_nxt = FETCH_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH_A;
      pc     <= RESET_PC;
      op_pc  <= RESET_PC;
      op_len <= 2'd0;
    end else begin
      state <= state_nxt;
      if (jmp_en)     pc <= jmp_addr;
      else if (|load) pc <= pc + ADDR_W'(1);
      if (load[0]) begin
        op_pc  <= pc;
        op_len <= len_bytes(bus.mem_data[7:6]);
      end
    end
  end

  opcode_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .load   (load),
    .data   (bus.mem_data),
    .opcode (bus.opcode)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed-vector bench for fetch_sequencer
module tb_fetch_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       jmp_en;
  logic [7:0] jmp_addr;
  logic       halt;
  logic       fault;
  logic       rdy_en;
  logic       op_ack;
  logic [7:0] mem_arr [256];
  logic [7:0] read_log [$];
  int         vectors = 0;
  int         errors  = 0;

  fetch_sequencer_if #(.ADDR_W(8)) bus ();

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h10)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .jmp_en   (jmp_en),
    .jmp_addr (jmp_addr),
    .halt     (halt),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = mem_arr[bus.mem_addr];
  assign bus.mem_rdy  = rdy_en;
  assign bus.op_ack   = op_ack;

  always @(posedge clk)
    if (bus.mem_req && bus.mem_rdy && !jmp_en && !rst) read_log.push_back(bus.mem_addr);

  task automatic do_jump(input logic [7:0] a);
    @(negedge clk);
    jmp_en = 1'b1; jmp_addr = a;
    @(negedge clk);
    jmp_en = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (bus.mem_addr !== 8'h10) begin errors++; $display("FAIL rst_mem_addr: got %h want 10", bus.mem_addr); end
    vectors++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL rst_op_valid: got %b want 0", bus.op_valid); end
    vectors++; if (bus.opcode !== 24'h0) begin errors++; $display("FAIL rst_opcode: got %h want 000000", bus.opcode); end
    vectors++; if (bus.op_len !== 2'd0 || bus.op_pc !== 8'h10) begin errors++; $display("FAIL rst_len_pc: got %0d/%h want 0/10", bus.op_len, bus.op_pc); end
    vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", fault); end
    rst = 1'b0;
    #1;
    vectors++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.mem_req); end
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b1 || bus.opcode !== 24'h050000) begin errors++; $display("FAIL first_op: got v=%b %h want v=1 050000", bus.op_valid, bus.opcode); end
    vectors++; if (bus.op_len !== 2'd1 || bus.op_pc !== 8'h10) begin errors++; $display("FAIL first_len_pc: got %0d/%h want 1/10", bus.op_len, bus.op_pc); end
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h11) begin errors++; $display("FAIL next_req: got v=%b req=%b addr=%h want 0/1/11", bus.op_valid, bus.mem_req, bus.mem_addr); end
    halt = 1'b1; op_ack = 1'b0;
  endtask

  task automatic test_wait_states;
    logic [23:0] held;
    do_jump(8'h20);
    halt = 1'b0; rdy_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h21) begin errors++; $display("FAIL wait_addr%0d: got req=%b addr=%h want 1/21", i, bus.mem_req, bus.mem_addr); end
      rdy_en = (i == 2);
    end
    @(negedge clk);
    vectors++; if (bus.mem_addr !== 8'h22) begin errors++; $display("FAIL byte_c_addr: got %h want 22", bus.mem_addr); end
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b1 || bus.opcode !== 24'h81AA55) begin errors++; $display("FAIL op3: got v=%b %h want v=1 81aa55", bus.op_valid, bus.opcode); end
    vectors++; if (bus.op_len !== 2'd3 || bus.op_pc !== 8'h20) begin errors++; $display("FAIL op3_len_pc: got %0d/%h want 3/20", bus.op_len, bus.op_pc); end
    held = bus.opcode;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (bus.op_valid !== 1'b1 || bus.mem_req !== 1'b0 || bus.opcode !== 24'h81AA55) begin errors++; $display("FAIL hold%0d: got v=%b req=%b %h want 1/0/81aa55", i, bus.op_valid, bus.mem_req, bus.opcode); end
    end
    op_ack = 1'b1;
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h23) begin errors++; $display("FAIL resume: got v=%b req=%b addr=%h want 0/1/23 (held %h)", bus.op_valid, bus.mem_req, bus.mem_addr, held); end
    halt = 1'b1; op_ack = 1'b0;
  endtask

  task automatic test_jump_abort;
    do_jump(8'h30);
    halt = 1'b0;
    @(negedge clk);
    vectors++; if (bus.mem_addr !== 8'h31) begin errors++; $display("FAIL abort_b_addr: got %h want 31", bus.mem_addr); end
    jmp_en = 1'b1; jmp_addr = 8'h40;
    @(negedge clk);
    jmp_en = 1'b0;
    vectors++; if (bus.mem_addr !== 8'h40 || bus.mem_req !== 1'b1 || bus.op_valid !== 1'b0) begin errors++; $display("FAIL jump_target: got addr=%h req=%b v=%b want 40/1/0", bus.mem_addr, bus.mem_req, bus.op_valid); end
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b1 || bus.opcode !== 24'h010000 || bus.op_pc !== 8'h40) begin errors++; $display("FAIL jump_op: got v=%b %h pc=%h want 1/010000/40", bus.op_valid, bus.opcode, bus.op_pc); end
    op_ack = 1'b1; halt = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
  endtask

  task automatic test_wrap;
    do_jump(8'hFE);
    read_log.delete();
    halt = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.opcode !== 24'h801122 || bus.op_pc !== 8'hFE || bus.op_len !== 2'd3) begin errors++; $display("FAIL wrap_op: got %h pc=%h len=%0d want 801122/fe/3", bus.opcode, bus.op_pc, bus.op_len); end
    vectors++;
    if (read_log.size() != 3) begin errors++; $display("FAIL wrap_reads: got %0d reads want 3", read_log.size()); end
    else if (read_log[0] !== 8'hFE || read_log[1] !== 8'hFF || read_log[2] !== 8'h00) begin errors++; $display("FAIL wrap_reads: got %h %h %h want fe ff 00", read_log[0], read_log[1], read_log[2]); end
    op_ack = 1'b1; halt = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
    vectors++; if (bus.mem_addr !== 8'h01) begin errors++; $display("FAIL wrap_next_pc: got %h want 01", bus.mem_addr); end
  endtask

  task automatic test_back_to_back;
    do_jump(8'h70);
    op_ack = 1'b1; halt = 1'b0;
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b1 || bus.opcode !== 24'h010000) begin errors++; $display("FAIL b2b_op1: got v=%b %h want 1/010000", bus.op_valid, bus.opcode); end
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b0 || bus.mem_addr !== 8'h71) begin errors++; $display("FAIL b2b_gap: got v=%b addr=%h want 0/71", bus.op_valid, bus.mem_addr); end
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b0 || bus.mem_addr !== 8'h72) begin errors++; $display("FAIL b2b_byte_b: got v=%b addr=%h want 0/72", bus.op_valid, bus.mem_addr); end
    halt = 1'b1;
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b1 || bus.opcode !== 24'h410200 || bus.op_pc !== 8'h71 || bus.op_len !== 2'd2) begin errors++; $display("FAIL b2b_op2: got v=%b %h pc=%h len=%0d want 1/410200/71/2", bus.op_valid, bus.opcode, bus.op_pc, bus.op_len); end
    @(negedge clk);
    op_ack = 1'b0;
  endtask

  task automatic test_halt_mid_opcode;
    do_jump(8'h80);
    halt = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    vectors++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL halt_mid_req: got %b want 1", bus.mem_req); end
    @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b1 || bus.opcode !== 24'h427700) begin errors++; $display("FAIL halt_mid_op: got v=%b %h want 1/427700", bus.op_valid, bus.opcode); end
    op_ack = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
    vectors++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 8'h82) begin errors++; $display("FAIL halt_gate: got req=%b addr=%h want 0/82", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_illegal;
    do_jump(8'h50);
    halt = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (fault !== 1'b1 || bus.mem_req !== 1'b0 || bus.op_valid !== 1'b0) begin errors++; $display("FAIL trap%0d: got fault=%b req=%b v=%b want 1/0/0", i, fault, bus.mem_req, bus.op_valid); end
    end
    vectors++; if (bus.opcode !== 24'hC00000 || bus.op_pc !== 8'h50) begin errors++; $display("FAIL trap_debug: got %h pc=%h want c00000/50", bus.opcode, bus.op_pc); end
    halt = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h60;
    @(negedge clk);
    jmp_en = 1'b0;
    vectors++; if (fault !== 1'b0 || bus.mem_addr !== 8'h60) begin errors++; $display("FAIL trap_exit: got fault=%b addr=%h want 0/60", fault, bus.mem_addr); end
`else
    repeat (3) @(negedge clk);
    vectors++; if (bus.op_valid !== 1'b1 || bus.opcode !== 24'hC01234 || bus.op_len !== 2'd3) begin errors++; $display("FAIL ill_as_3: got v=%b %h len=%0d want 1/c01234/3", bus.op_valid, bus.opcode, bus.op_len); end
    vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL ill_fault: got %b want 0", fault); end
    halt = 1'b1; op_ack = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
    mem_arr[8'h10] = 8'h05;
    mem_arr[8'h20] = 8'h81; mem_arr[8'h21] = 8'hAA; mem_arr[8'h22] = 8'h55;
    mem_arr[8'h30] = 8'h40; mem_arr[8'h31] = 8'h99; mem_arr[8'h40] = 8'h01;
    mem_arr[8'hFE] = 8'h80; mem_arr[8'hFF] = 8'h11; mem_arr[8'h00] = 8'h22;
    mem_arr[8'h50] = 8'hC0; mem_arr[8'h51] = 8'h12; mem_arr[8'h52] = 8'h34;
    mem_arr[8'h70] = 8'h01; mem_arr[8'h71] = 8'h41; mem_arr[8'h72] = 8'h02;
    mem_arr[8'h80] = 8'h42; mem_arr[8'h81] = 8'h77;
    rst = 1'b1; jmp_en = 1'b0; jmp_addr = 8'h00; halt = 1'b0; rdy_en = 1'b1; op_ack = 1'b1;
    test_reset();
    test_wait_states();
    test_jump_abort();
    test_wrap();
    test_back_to_back();
    test_halt_mid_opcode();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
